// File: rtl/dct_coef_mac_if.sv
// rtl/dct_coef_mac_if.sv - sample-in / result-out handshake bundle for dct_coef_mac
interface dct_coef_mac_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  // The MAC consumes samples and produces results.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // The sample buffer / zig-zag side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dct_coef_mac.sv
// rtl/dct_coef_mac.sv - per-lane DCT coefficient MAC; DCT_COEF_MAC_SAT_EN enables output clamp and sat_flag
module dct_coef_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 12,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [TAPS*COEF_W-1:0]     coef_tbl,
  dct_coef_mac_if.slave              bus,
  output logic [$clog2(TAPS)-1:0]    tap_idx
`ifdef DCT_COEF_MAC_SAT_EN
  ,
  output logic                       sat_flag
`endif
);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  // One spare bit so the rounding constant can never wrap the sum.
  localparam int RND_W  = ACC_W + 1;
  localparam int EXT_W  = (RND_W > OUT_W) ? RND_W : OUT_W;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RND_W-1:0] RND_C =
    (SHIFT > 0) ? (RND_W'(1) << RND_SH) : '0;

  logic signed [ACC_W-1:0]  acc_q, acc_nxt, acc_base, total;
  logic [IDX_W-1:0]         idx_q, idx_nxt;
  logic                     ov_q, ov_nxt;
  logic signed [OUT_W-1:0]  od_q, od_nxt;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [RND_W-1:0]  rnd, r;
  logic signed [EXT_W-1:0]  r_ext;
  logic [OUT_W-1:0]         r_fmt;
  logic                     accept, last;

`ifdef DCT_COEF_MAC_SAT_EN
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;
  logic sat_q, sat_nxt, clamp;
`endif

  assign bus.in_ready  = !clr && (!ov_q || bus.out_ready);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign tap_idx       = idx_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = (idx_q == IDX_W'(TAPS - 1));
`ifdef DCT_COEF_MAC_SAT_EN
  assign sat_flag      = sat_q;
`endif

  // Pick the coefficient of the tap about to be accepted.
  always_comb begin
    coef_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx_q == IDX_W'(k)) coef_sel = coef_tbl[k*COEF_W +: COEF_W];
    end
  end

  // Product, running total, round-half-up shift and reduction to OUT_W.
  always_comb begin
    prod     = PROD_W'(bus.in_data) * PROD_W'(coef_sel);
    acc_base = (idx_q == '0) ? '0 : acc_q;
    total    = acc_base + ACC_W'(prod);
    rnd      = RND_W'(total) + RND_C;
    r        = rnd >>> SHIFT;
    r_ext    = EXT_W'(r);
`ifdef DCT_COEF_MAC_SAT_EN
    clamp = 1'b0;
    if (r_ext > MAX_V) begin
      r_fmt = MAX_V[OUT_W-1:0];
      clamp = 1'b1;
    end else if (r_ext < MIN_V) begin
      r_fmt = MIN_V[OUT_W-1:0];
      clamp = 1'b1;
    end else begin
      r_fmt = r_ext[OUT_W-1:0];
    end
`else
    r_fmt = OUT_W'(r_ext);
`endif
  end

  // Next-state: output drain, block abort, beat accumulation / block completion.
  always_comb begin
    acc_nxt = acc_q;
    idx_nxt = idx_q;
    ov_nxt  = ov_q;
    od_nxt  = od_q;
`ifdef DCT_COEF_MAC_SAT_EN
    sat_nxt = sat_q;
`endif
    if (ov_q && bus.out_ready) ov_nxt = 1'b0;
    if (clr) begin
      acc_nxt = '0;
      idx_nxt = '0;
`ifdef DCT_COEF_MAC_SAT_EN
      sat_nxt = 1'b0;
`endif
    end else if (accept) begin
      if (last) begin
        od_nxt  = r_fmt;
        ov_nxt  = 1'b1;
        acc_nxt = '0;
        idx_nxt = '0;
`ifdef DCT_COEF_MAC_SAT_EN
        sat_nxt = sat_q | clamp;
`endif
      end else begin
        acc_nxt = total;
        idx_nxt = idx_q + IDX_W'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
`ifdef DCT_COEF_MAC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_nxt;
      idx_q <= idx_nxt;
      ov_q  <= ov_nxt;
      od_q  <= od_nxt;
`ifdef DCT_COEF_MAC_SAT_EN
      sat_q <= sat_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_dct_coef_mac.sv
// tb/tb_dct_coef_mac.sv - directed bench for dct_coef_mac across three parameter sets
module tb_dct_coef_mac;
  logic clk = 1'b0;
  logic rst;
  logic clr0, clr1, clr2;
  logic [8*12-1:0] coef0, coef2;
  logic [2*12-1:0] coef1;
  logic [2:0] ti0, ti2;
  logic [0:0] ti1;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dct_coef_mac_if #(.DATA_W(8), .OUT_W(16)) b0 ();
  dct_coef_mac_if #(.DATA_W(8), .OUT_W(12)) b1 ();
  dct_coef_mac_if #(.DATA_W(8), .OUT_W(12)) b2 ();

`ifdef DCT_COEF_MAC_SAT_EN
  logic sf0, sf1, sf2;
`endif

  dct_coef_mac #(.DATA_W(8), .COEF_W(12), .TAPS(8), .SHIFT(0), .OUT_W(16)) u0 (
    .clk(clk), .rst(rst), .clr(clr0), .coef_tbl(coef0), .bus(b0.slave), .tap_idx(ti0)
`ifdef DCT_COEF_MAC_SAT_EN
    , .sat_flag(sf0)
`endif
  );

  dct_coef_mac #(.DATA_W(8), .COEF_W(12), .TAPS(2), .SHIFT(1), .OUT_W(12)) u1 (
    .clk(clk), .rst(rst), .clr(clr1), .coef_tbl(coef1), .bus(b1.slave), .tap_idx(ti1)
`ifdef DCT_COEF_MAC_SAT_EN
    , .sat_flag(sf1)
`endif
  );

  dct_coef_mac #(.DATA_W(8), .COEF_W(12), .TAPS(8), .SHIFT(8), .OUT_W(12)) u2 (
    .clk(clk), .rst(rst), .clr(clr2), .coef_tbl(coef2), .bus(b2.slave), .tap_idx(ti2)
`ifdef DCT_COEF_MAC_SAT_EN
    , .sat_flag(sf2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat0(input int d);
    b0.in_valid = 1'b1;
    b0.in_data  = d[7:0];
    tick();
  endtask

  task automatic beat1(input int d);
    b1.in_valid = 1'b1;
    b1.in_data  = d[7:0];
    tick();
  endtask

  task automatic beat2(input int d);
    b2.in_valid = 1'b1;
    b2.in_data  = d[7:0];
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    coef0 = {8{12'd1}};
    coef1 = {2{12'd1}};
    coef2 = {8{12'd2047}};
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_tap_idx", ti0, 0);
    chk("rst_out_data", b0.out_data, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    rst = 1'b0;

    // Samples 1..8, all coef 1, no shift, then a back-to-back block of 10s
    for (int i = 1; i <= 8; i++) begin
      beat0(i);
      if (i == 7) chk("sum36_not_early", b0.out_valid, 0);
    end
    chk("sum36_valid", b0.out_valid, 1);
    chk("sum36_data", b0.out_data, 36);
    chk("sum36_tap_idx", ti0, 0);
    beat0(10);
    chk("b2b_valid_drop", b0.out_valid, 0);
    chk("b2b_tap_idx", ti0, 1);
    for (int i = 2; i <= 8; i++) beat0(10);
    chk("b2b_valid", b0.out_valid, 1);
    chk("b2b_data", b0.out_data, 80);
    b0.in_valid = 1'b0;
    tick();
    chk("b2b_drain", b0.out_valid, 0);

    // TAPS=2, SHIFT=1 rounding
    beat1(1);
    beat1(2);
    chk("rnd_pos_valid", b1.out_valid, 1);
    chk("rnd_pos_data", b1.out_data, 2);
    beat1(-1);
    chk("rnd_mid_valid", b1.out_valid, 0);
    beat1(-2);
    chk("rnd_neg_valid", b1.out_valid, 1);
    chk("rnd_neg_data", b1.out_data, -1);
    b1.in_valid = 1'b0;
    tick();

    // Overflow of the 12-bit output: 127*2047*8 -> 8124 after shift
    for (int i = 0; i < 8; i++) beat2(127);
    chk("ovf_valid", b2.out_valid, 1);
`ifdef DCT_COEF_MAC_SAT_EN
    chk("ovf_data_sat", b2.out_data, 2047);
    chk("ovf_sat_flag", sf2, 1);
    chk("nosat_flag_u0", sf0, 0);
`else
    chk("ovf_data_wrap", b2.out_data, -68);
`endif
    b2.in_valid = 1'b0;
    tick();
`ifdef DCT_COEF_MAC_SAT_EN
    chk("sat_flag_sticky", sf2, 1);
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("sat_flag_clr", sf2, 0);
`endif

    // Backpressure: result held for 5 cycles with in_valid high
    b0.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) beat0(i);
    chk("bp_valid", b0.out_valid, 1);
    chk("bp_data", b0.out_data, 36);
    for (int k = 0; k < 5; k++) begin
      b0.in_valid = 1'b1;
      b0.in_data  = 8'(100 + k);
      #1;
      chk("bp_in_ready", b0.in_ready, 0);
      tick();
      chk("bp_hold_data", b0.out_data, 36);
      chk("bp_hold_valid", b0.out_valid, 1);
    end
    b0.out_ready = 1'b1;
    beat0(2);
    chk("bp_release_valid", b0.out_valid, 0);
    chk("bp_release_tap", ti0, 1);
    for (int i = 2; i <= 8; i++) beat0(2 * i);
    chk("bp_next_valid", b0.out_valid, 1);
    chk("bp_next_data", b0.out_data, 72);
    b0.in_valid = 1'b0;
    tick();

    // clr after 3 taps with a beat presented in the clr cycle
    beat0(5); beat0(5); beat0(5);
    chk("clr_pre_tap", ti0, 3);
    clr0 = 1'b1;
    b0.in_valid = 1'b1;
    b0.in_data  = 8'd50;
    #1;
    chk("clr_in_ready", b0.in_ready, 0);
    tick();
    clr0 = 1'b0;
    chk("clr_tap_idx", ti0, 0);
    chk("clr_no_valid", b0.out_valid, 0);
    for (int i = 1; i <= 8; i++) beat0(i);
    chk("clr_post_valid", b0.out_valid, 1);
    chk("clr_post_data", b0.out_data, 36);
    // clr while a result is pending leaves it pending
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b0;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_hold_valid", b0.out_valid, 1);
    chk("clr_hold_data", b0.out_data, 36);
    b0.out_ready = 1'b1;
    tick();
    chk("clr_hold_drain", b0.out_valid, 0);

    // rst in HOLD
    b0.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) beat0(i);
    b0.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_hold_valid", b0.out_valid, 0);
    chk("rst_hold_tap", ti0, 0);
    chk("rst_hold_data", b0.out_data, 0);
    chk("rst_hold_in_ready", b0.in_ready, 1);
    rst = 1'b0;
    b0.out_ready = 1'b1;
    // rst mid-ACC
    beat0(3); beat0(3); beat0(3);
    b0.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_acc_tap", ti0, 0);
    chk("rst_acc_valid", b0.out_valid, 0);
    for (int i = 1; i <= 8; i++) beat0(9 - i);
    chk("rst_post_valid", b0.out_valid, 1);
    chk("rst_post_data", b0.out_data, 36);
    b0.in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dct_coef_mac.md
Name: dct_coef_mac

Overview:
- Parametrised multiply-accumulate unit that computes one DCT coefficient from a stream of TAPS signed samples, using a static per-tap coefficient table.
- Successor to the fixed-width per-unit coefficient register in the fdct datapath. It generalises sample width, coefficient width, tap count and output scaling.
- Adds valid/ready handshakes, output backpressure, a synchronous block clear and optional output saturation.
- Sits between the row/column sample buffer and the zig-zag reorder stage; one instance per coefficient lane.

Parameters:
- DATA_W, 8: signed sample width.
- COEF_W, 12: signed coefficient width.
- TAPS, 8: samples per block; must be at least 2.
- SHIFT, 8: right-shift applied to the accumulator before output, with rounding; 0 means no shift.
- OUT_W, 12: signed output width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous block abort; discards the partial accumulation.
- coef_tbl  in  TAPS*COEF_W  coefficient table. Tap k occupies bits [k*COEF_W +: COEF_W]. Quasi-static: change only while idle.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_data  in  DATA_W  signed sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  signed rounded result.
- tap_idx  out  clog2(TAPS)  index of the next tap to be accepted.

Behaviour:
- Widths:
  - product: DATA_W+COEF_W, signed.
  - acc: ACC_W = DATA_W+COEF_W+clog2(TAPS), signed, sign-extended products; no internal overflow is possible.
- States: IDLE (tap_idx=0, no result pending), ACC (0<tap_idx<TAPS), HOLD (out_valid=1).
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A beat is accepted when in_valid && in_ready.
- On each accepted beat:
  - tap_idx < TAPS-1: acc <= (tap_idx==0 ? 0 : acc) + in_data*coef[tap_idx]; tap_idx increments.
  - tap_idx == TAPS-1 (last beat): total = acc + product; out_data <= fmt(total); out_valid <= 1; acc <= 0; tap_idx <= 0.
- fmt():
  - r = (total + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, i.e. round-half-up in arithmetic shift.
  - r is then reduced to OUT_W as defined under Optional Feature.
- Latency: out_valid is high in the cycle after the last tap is accepted.
- Throughput: one sample per cycle, sustained with no bubble between blocks while out_ready=1.
- Output hold:
  - out_valid && !out_ready: out_data is held stable; in_ready=0.
  - out_valid && out_ready: out_valid clears unless a new last beat is accepted in the same cycle, in which case out_valid stays 1 with the new data.
- clr:
  - Zeroes acc and tap_idx.
  - Does not drop a pending out_valid.
  - Overrides a beat presented in the same cycle; that beat is not accepted and in_ready is forced to 0 while clr=1.
- rst (including mid-block): acc=0, tap_idx=0, out_valid=0, out_data=0. Outputs then read in_ready=1.
- in_valid low between taps: state holds indefinitely; there is no timeout.

Optional Feature:
- Macro: DCT_COEF_MAC_SAT_EN.
- Defined: r is clamped to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1], and sticky output sat_flag (1 bit) is added.
  - sat_flag is set when a clamp occurs.
  - sat_flag is cleared by rst or by clr.
- Undefined: r is truncated to its low OUT_W bits (two's-complement wrap), and no sat_flag port exists.

Test Plan:
- Defaults with SHIFT=0, OUT_W=16, all coef=1: samples 1..8 streamed back-to-back -> out_valid exactly one cycle after 8th beat, out_data=36, tap_idx returns to 0.
- SHIFT=1, TAPS=2, coef={1,1}: samples {1,2} -> out_data=2 (3 rounds up); samples {-1,-2} -> out_data=-1.
- Defaults, all samples 127, all coef 2047:
  - total 2079752 -> r=8124.
  - With DCT_COEF_MAC_SAT_EN: out_data=2047, sat_flag=1.
  - Without it: out_data=-68.
- Backpressure: out_ready=0 for 5 cycles after result, in_valid held high -> in_ready=0, out_data stable. Raise out_ready -> next block accumulates with no lost or duplicated beat.
- clr asserted after 3 taps, with in_valid high in the clr cycle -> beat ignored, tap_idx=0. The next 8 beats produce a result using only post-clr samples.
- rst asserted in HOLD and mid-ACC -> next cycle out_valid=0, tap_idx=0, out_data=0. The next full block is computed correctly.
